// File: rtl/gcd_job_seq.sv
// Job sequencer between the APB register file and the GCD core: launch, timeout, constant-time padding.
// Optional external abort input enabled by defining GCD_SEQ_ABORT_EN.
module gcd_job_seq #(
   parameter int unsigned CT_CYCLES = 1024,
   parameter int unsigned TIMEOUT   = 2048
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        START_PULSE,
   input  logic [2:0]  OPCODE,
   input  logic        CONSTANT_TIME,
`ifdef GCD_SEQ_ABORT_EN
   input  logic        ABORT,
`endif
   output logic        CORE_REQ,
   output logic [2:0]  CORE_OPCODE,
   input  logic        CORE_ACK,
   input  logic        CORE_DONE,
   output logic        CORE_ABORT,
   output logic        BUSY,
   output logic        DONE_PULSE,
   output logic [11:0] CYCLE_COUNT,
   output logic [1:0]  DONE_CODE,
   output logic        OVERRUN
);

   localparam int unsigned CNT_W  = 12;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned CODE_W = 2;

   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  CT_C      = CNT_W'(CT_CYCLES);
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [OP_W-1:0]   OP_MAX    = OP_W'(4);

   localparam logic [CODE_W-1:0] CODE_OK  = CODE_W'(0);
   localparam logic [CODE_W-1:0] CODE_TMO = CODE_W'(1);
   localparam logic [CODE_W-1:0] CODE_ILL = CODE_W'(2);
   localparam logic [CODE_W-1:0] CODE_ABT = CODE_W'(3);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      RUN  = 3'd2,
      PAD  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [CODE_W-1:0]  code_nx;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   n_c;
   logic               ct;
   logic               kill;
   logic               counting_c;
   logic               legal_op_c;
   logic               abort_c;

`ifdef GCD_SEQ_ABORT_EN
   assign abort_c = ABORT;
`else
   assign abort_c = 1'b0;
`endif

   assign counting_c = (state == REQ) || (state == RUN) || (state == PAD);
   assign legal_op_c = (OPCODE <= OP_MAX);
   // Value the counter takes on this edge; saturates at the 12-bit ceiling
   assign n_c        = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // State register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) state <= IDLE;
      else         state <= state_nx;
   end

   // Next state and completion code; abort outranks everything else
   always_comb begin
      state_nx = state;
      code_nx  = CODE_OK;
      case (state)
         IDLE: begin
            if (START_PULSE) begin
               state_nx = legal_op_c ? REQ : DONE;
               code_nx  = legal_op_c ? CODE_OK : CODE_ILL;
            end
         end
         REQ: begin
            if (abort_c) begin
               state_nx = DONE;
               code_nx  = CODE_ABT;
            end else if (CORE_ACK) begin
               state_nx = RUN;
            end else if (n_c == TIMEOUT_C) begin
               state_nx = DONE;
               code_nx  = CODE_TMO;
            end
         end
         RUN: begin
            if (abort_c) begin
               state_nx = DONE;
               code_nx  = CODE_ABT;
            end else if (CORE_DONE) begin
               state_nx = (ct && (n_c < CT_C)) ? PAD : DONE;
            end else if (n_c == TIMEOUT_C) begin
               state_nx = DONE;
               code_nx  = CODE_TMO;
            end
         end
         PAD: begin
            if (abort_c) begin
               state_nx = DONE;
               code_nx  = CODE_ABT;
            end else if (n_c == CT_C) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Moore outputs decoded from the state register
   always_comb begin
      CORE_REQ   = 1'b0;
      BUSY       = 1'b0;
      DONE_PULSE = 1'b0;
      CORE_ABORT = 1'b0;
      case (state)
         REQ: begin
            CORE_REQ = 1'b1;
            BUSY     = 1'b1;
         end
         RUN:  BUSY = 1'b1;
         PAD:  BUSY = 1'b1;
         DONE: begin
            BUSY       = 1'b1;
            DONE_PULSE = 1'b1;
            CORE_ABORT = kill;
         end
         default: ;
      endcase
   end

   // Job context, counter and result registers
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt         <= '0;
         ct          <= 1'b0;
         kill        <= 1'b0;
         CORE_OPCODE <= '0;
         CYCLE_COUNT <= '0;
         DONE_CODE   <= '0;
         OVERRUN     <= 1'b0;
      end else begin
         if (counting_c) cnt <= n_c;

         if (state == IDLE) begin
            if (START_PULSE) begin
               OVERRUN <= 1'b0;
               kill    <= 1'b0;
               if (legal_op_c) begin
                  CORE_OPCODE <= OPCODE;
                  ct          <= CONSTANT_TIME;
                  cnt         <= '0;
               end else begin
                  CYCLE_COUNT <= '0;
                  DONE_CODE   <= CODE_ILL;
               end
            end
         end else if (START_PULSE) begin
            OVERRUN <= 1'b1;
         end

         // Core is only killed when it was still holding the job (REQ/RUN)
         if (counting_c && (state_nx == DONE)) begin
            CYCLE_COUNT <= n_c;
            DONE_CODE   <= code_nx;
            kill        <= (state != PAD) && code_nx[0];
         end
      end
   end

endmodule
